uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter ClkFrequency, default 100000000, SHALL give the clk frequency in Hz.
REQ-002 Parameter Baud, default 115200, SHALL give the line bit rate in bit/s.
REQ-003 Derived constant BIT_CLKS = ClkFrequency/Baud (integer division) SHALL be the bit period in clk cycles; 868 at the defaults.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-005 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-006 Tx_start  input  1  SHALL request transmission of Tx_data; it is sampled each cycle.
REQ-007 Tx_data  input  8  SHALL carry the byte to send; it is sampled only in the accept cycle.
REQ-008 TxD  output  1  SHALL be the serial line, registered, idle high.
REQ-009 Tx_busy  output  1  SHALL be high while a frame is in progress.
REQ-010 Tx_done  output  1  SHALL be a one-cycle pulse at frame completion.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); no parity.
REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP; any unused encoding SHALL return to IDLE on the next edge.
REQ-013 Accept: in IDLE with Tx_start=1 at edge k, the block SHALL latch Tx_data into a shift register, clear the bit counter, enter START, and set TxD=0 and Tx_busy=1 from edge k.
REQ-014 The bit counter SHALL count 0..BIT_CLKS-1 and wrap to 0 at each bit boundary; every bit SHALL last exactly BIT_CLKS cycles, with no fractional accumulation.
REQ-015 START SHALL last BIT_CLKS cycles, then move to DATA with TxD = data[0].
REQ-016 DATA SHALL use a 3-bit index; each bit boundary SHALL shift the register right and drive the next bit; after bit 7 the FSM SHALL enter STOP with TxD=1.
REQ-017 At the end of STOP (edge k+10*BIT_CLKS), the FSM SHALL enter IDLE, set Tx_busy=0 and Tx_done=1 for exactly one cycle, and hold TxD=1.
REQ-018 Tx_start while Tx_busy=1 SHALL be ignored: no queuing, and the in-flight frame is unaffected.
REQ-019 Changes on Tx_data after the accept edge SHALL NOT affect the frame in progress.
REQ-020 Tx_start=1 in the cycle Tx_done=1 SHALL be accepted, because the FSM is in IDLE; this gives back-to-back frames with no idle bit time.
REQ-021 Tx_start held high continuously SHALL produce back-to-back frames, re-sampling Tx_data at each accept.
REQ-022 All outputs SHALL be driven from flops, with no combinational path from inputs to outputs.
REQ-023 BIT_CLKS < 2 SHALL be an illegal configuration, flagged by a simulation-time error.

Reset
REQ-024 With rst=1 at an edge, the next state SHALL be: FSM=IDLE, TxD=1, Tx_busy=0, Tx_done=0, counters=0, shift register=0.
REQ-025 Reset SHALL take priority over Tx_start in the same cycle, and the request SHALL be dropped.
REQ-026 Reset mid-frame SHALL abandon the frame, return TxD high on the next edge, and SHALL NOT pulse Tx_done.
REQ-027 The power-up initial values of all flops SHALL equal the reset values.

Verification (ClkFrequency=1000, Baud=100, so BIT_CLKS=10)
REQ-028 Single byte: reset, then Tx_start for one cycle with Tx_data=8'hA5 -> TxD = 0,1,0,1,0,0,1,0,1,1 with each bit held 10 cycles; Tx_busy high for 100 cycles; Tx_done one pulse at cycle 100; no rx sampling/decoding is expected of the bench beyond these checks.
REQ-029 Busy-ignore: accept 8'h0F, pulse Tx_start with Tx_data=8'hFF at cycle 35 -> the line carries 8'h0F only, with exactly one Tx_done.
REQ-030 Back-to-back: Tx_start held high with Tx_data=8'h00, then 8'hFF from cycle 50 -> the first frame is all zeros plus stop; the second starts at cycle 100 with data 8'hFF; TxD is never high between them except the stop bit.
REQ-031 Reset mid-frame: accept 8'h55, assert rst at cycle 47 -> TxD=1, Tx_busy=0 at the next edge; no Tx_done; a fresh Tx_start then yields a correct 8'h55 frame.
REQ-032 Data hold: accept 8'h3C, then change Tx_data every cycle -> the serialized bits still equal 8'h3C.
REQ-033 Reset vs start: rst=1 and Tx_start=1 in the same cycle -> TxD stays 1 and Tx_busy stays 0.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with registered outputs and one-cycle done pulse
module uart_transmitter #(
  parameter int ClkFrequency = 100000000,
  parameter int Baud = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Tx_start,
  input  logic [7:0] Tx_data,
  output logic       TxD,
  output logic       Tx_busy,
  output logic       Tx_done
);
  localparam int BIT_CLKS = ClkFrequency / Baud;
  localparam int CW = BIT_CLKS > 1 ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CLKS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  if (BIT_CLKS < 2) begin : g_bad_cfg
    $error("uart_transmitter: BIT_CLKS = %0d, must be at least 2", BIT_CLKS);
  end
  state_t state = IDLE;
  logic [CW-1:0] cnt = '0;
  logic [2:0] bit_idx = '0;
  logic [7:0] shreg = '0;
  logic txd_q = 1'b1;
  logic busy_q = 1'b0;
  logic done_q = 1'b0;
  logic wrap;
  assign wrap = cnt == LAST;
  assign TxD = txd_q;
  assign Tx_busy = busy_q;
  assign Tx_done = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt <= (state == IDLE || wrap) ? '0 : cnt + 1'b1;
      case (state)
        IDLE: if (Tx_start) begin
          shreg <= Tx_data;
          state <= START;
          txd_q <= 1'b0;
          busy_q <= 1'b1;
        end
        START: if (wrap) begin
          state <= DATA;
          txd_q <= shreg[0];
          shreg <= shreg >> 1;
          bit_idx <= '0;
        end
        DATA: if (wrap) begin
          if (bit_idx == 3'd7) begin
            state <= STOP;
            txd_q <= 1'b1;
          end else begin
            txd_q <= shreg[0];
            shreg <= shreg >> 1;
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: if (wrap) begin
          state <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: begin
          state <= IDLE;
          txd_q <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule
